// File: rtl/serial_chunk_adder_pkg.sv
// Shared definitions for the serial chunk adder: FSM encoding, slice width
// and the chunk-counter width helper.
package serial_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CHUNK_W = 2;

  // Counter width for n chunks; a single-chunk adder still needs one bit.
  function automatic int cnt_w(input int nchunk);
    int w;
    w = $clog2(nchunk);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_chunk_adder_slice_adder2.sv
// Two-bit combinational slice adder; the only arithmetic in the serial adder,
// reused on every chunk cycle.
module slice_adder2
  import serial_chunk_adder_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] s,
  output logic               cout
);

  logic [CHUNK_W:0] sum_s;

  // Zero-extend both chunks so the top bit of the sum is the carry-out.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};
  end

  assign s    = sum_s[CHUNK_W-1:0];
  assign cout = sum_s[CHUNK_W];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: processes WIDTH-bit operands two bits per clock through
// slice_adder2 with a registered carry. Define SERIAL_CHUNK_ADDER_SUB_EN to
// add the sub input (x - y, carry=1 meaning no borrow).
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             carry
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int CW     = cnt_w(NCHUNK);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   x_r;
  logic [WIDTH-1:0]   y_r;
  logic [WIDTH-1:0]   sum_r;
  logic [WIDTH-1:0]   sum_next_s;
  logic [CW-1:0]      cnt_r;
  logic               cin_r;
  logic               sub_r;
  logic               sub_in_s;
  logic [WIDTH-1:0]   z_r;
  logic               carry_r;
  logic               busy_r;
  logic               done_r;
  logic               busy_s;
  logic               done_s;
  logic               accept_s;
  logic               last_s;
  logic [CHUNK_W-1:0] a_s;
  logic [CHUNK_W-1:0] b_s;
  logic [CHUNK_W-1:0] s_s;
  logic               cout_s;
  int                 idx_s;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  assign sub_in_s = sub;
`else
  assign sub_in_s = 1'b0;
`endif

  assign accept_s = (state_r == IDLE) && start;
  assign last_s   = (cnt_r == LAST_CHUNK);

  // Select the current chunk; subtraction inverts y and relies on cin=1.
  always_comb begin
    idx_s      = CHUNK_W * int'(cnt_r);
    a_s        = x_r[idx_s +: CHUNK_W];
    b_s        = y_r[idx_s +: CHUNK_W] ^ {CHUNK_W{sub_r}};
    sum_next_s = sum_r;
    sum_next_s[idx_s +: CHUNK_W] = s_s;
  end

  slice_adder2 u_slice (
    .a    (a_s),
    .b    (b_s),
    .cin  (cin_r),
    .s    (s_s),
    .cout (cout_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so the flops track the state.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      RUN:     busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Operand capture, per-chunk accumulation and result load on RUN exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r     <= {WIDTH{1'b0}};
      y_r     <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      cin_r   <= 1'b0;
      sub_r   <= 1'b0;
      z_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r   <= x;
            y_r   <= y;
            sum_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
            cin_r <= sub_in_s;
            sub_r <= sub_in_s;
          end
        end
        RUN: begin
          sum_r <= sum_next_s;
          cin_r <= cout_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            z_r     <= sum_next_s;
            carry_r <= cout_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign z     = z_r;
  assign carry = carry_r;

endmodule
